neuron_mac: RTL and testbench

Fixed-point multiply-accumulate neuron stage. It consumes a stream of N_INPUTS (activation, weight) pairs in Q8.8, adds a Q8.8 bias, and rescales the sum back to Q8.8. The result is saturated to 16-bit signed and presented on a valid/ready output. It sits directly upstream of the `relu` activation: `y` is the pre-activation value that feeds `relu.a`.

---
 rtl/neuron_mac.sv | 116 +++++++++++
 tb/tb_neuron_mac.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - Q8.8 multiply-accumulate neuron stage with bias, floor rescale and saturation
module neuron_mac #(
  parameter int N_INPUTS  = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic              sat,
  output logic              busy
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  // Saturation limits expressed at accumulator width so the compare is a plain signed compare.
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]       Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;

  state_t                   state, state_n;
  logic signed [ACC_W-1:0]  acc, acc_n;
  logic [CNT_W-1:0]         count, count_n;
  logic [DATA_W-1:0]        y_n;
  logic                     sat_n;

  logic signed [2*DATA_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, s;
  logic                       last_beat;

  // Full-precision product and the aligned bias; the shift by FRAC_BITS puts the bias in Q16.16.
  assign x_ext     = {{DATA_W{x[DATA_W-1]}}, x};
  assign w_ext     = {{DATA_W{w[DATA_W-1]}}, w};
  assign prod      = x_ext * w_ext;
  assign prod_ext  = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_BITS;
  assign s         = acc >>> FRAC_BITS;
  assign last_beat = (count == CNT_W'(N_INPUTS - 1));

  // Handshake flags come from registered state only.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  // Next-state and datapath updates for each phase of an evaluation.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    count_n = count;
    y_n     = y;
    sat_n   = sat;
    case (state)
      IDLE: begin
        if (start) begin
          acc_n   = bias_ext;
          count_n = '0;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_n   = acc + prod_ext;
          count_n = count + 1'b1;
          if (last_beat) state_n = NORM;
        end
      end
      NORM: begin
        if (s > S_MAX) begin
          y_n   = Y_MAX;
          sat_n = 1'b1;
        end else if (s < S_MIN) begin
          y_n   = Y_MIN;
          sat_n = 1'b1;
        end else begin
          y_n   = s[DATA_W-1:0];
          sat_n = 1'b0;
        end
        state_n = OUT;
      end
      OUT: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any evaluation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      y     <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      count <= count_n;
      y     <= y_n;
      sat   <= sat_n;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed self-checking bench for neuron_mac
module tb_neuron_mac;
  localparam int N = 4;
  typedef logic [0:N-1][15:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bias = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = 16'h0;
  logic [15:0] w = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] y;
  logic        sat;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int hs = 0;
  logic [16:0] exp_q[$];

  neuron_mac #(.N_INPUTS(N), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: exact Q16.16 sum in 64-bit arithmetic, floor to Q8.8, clip to 16-bit signed.
  function automatic logic [16:0] model(input logic [15:0] b, input vec_t xs, input vec_t ws);
    longint acc;
    acc = longint'($signed(b)) * 256;
    for (int i = 0; i < N; i++)
      acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    acc = acc >>> 8;
    if (acc > 32767) return {1'b1, 16'h7FFF};
    if (acc < -32768) return {1'b1, 16'h8000};
    return {1'b0, acc[15:0]};
  endfunction

  // Every cycle a result is presented it must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        chk("y", {16'h0, y}, {16'h0, exp_q[0][15:0]});
        chk("sat", {31'h0, sat}, {31'h0, exp_q[0][16]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          hs++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input logic [15:0] xv, input logic [15:0] wv);
    int g;
    g = 0;
    in_valid = 1'b1;
    x = xv;
    w = wv;
    while (!in_ready && g < 20) begin
      tick();
      g++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    x = 16'hA5A5;
    w = 16'h5A5A;
  endtask

  task automatic run(input logic [15:0] b, input vec_t xs, input vec_t ws,
                     input bit gaps, input int hold);
    exp_q.push_back(model(b, xs, ws));
    bias = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    bias = 16'hDEAD;
    chk("in_ready_after_start", {31'h0, in_ready}, 32'd1);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        x = 16'($urandom);
        w = 16'($urandom);
        tick();
      end
      feed(xs[i], ws[i]);
    end
    chk("norm_out_valid", {31'h0, out_valid}, 32'd0);
    chk("norm_in_ready", {31'h0, in_ready}, 32'd0);
    tick();
    chk("out_valid_t2", {31'h0, out_valid}, 32'd1);
    for (int k = 0; k < hold; k++) begin
      start = k[0];
      in_valid = 1'b1;
      chk("hold_in_ready", {31'h0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'h0, out_valid}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    start = (hold > 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("out_valid_drop", {31'h0, out_valid}, 32'd0);
    chk("busy_drop", {31'h0, busy}, 32'd0);
  endtask

  vec_t bx, bw, px, pw, nw, fx, fw, zero_v;
  int hs0, g;

  initial begin
    bx = {16'h0100, 16'hFF00, 16'h0080, 16'h0000};
    bw = {16'h0200, 16'h0080, 16'h0080, 16'h0300};
    px = {16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    pw = px;
    nw = {16'h8100, 16'h8100, 16'h8100, 16'h8100};
    fx = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    fw = {16'h0080, 16'h0000, 16'h0000, 16'h0000};
    zero_v = '0;

    chk("model_basic", {15'h0, model(16'h0080, bx, bw)}, 32'h00240);
    chk("model_satp", {15'h0, model(16'h0000, px, pw)}, 32'h17FFF);
    chk("model_satn", {15'h0, model(16'h0000, px, nw)}, 32'h18000);
    chk("model_floor", {15'h0, model(16'h0000, fx, fw)}, 32'h0FFFF);

    #12;
    chk("reset_outputs", {11'h0, y, sat, out_valid, in_ready, busy}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    run(16'h0080, bx, bw, 1'b0, 0);
    chk("basic_lit", {15'h0, sat, y}, 32'h00240);
    run(16'h0000, px, pw, 1'b0, 0);
    chk("satp_lit", {15'h0, sat, y}, 32'h17FFF);
    run(16'h0000, px, nw, 1'b0, 0);
    chk("satn_lit", {15'h0, sat, y}, 32'h18000);
    chk("y_held_idle", {15'h0, sat, y}, 32'h18000);
    run(16'h0000, fx, fw, 1'b0, 0);
    chk("floor_lit", {15'h0, sat, y}, 32'h0FFFF);
    run(16'h0080, bx, bw, 1'b1, 5);
    chk("gaps_hold_lit", {15'h0, sat, y}, 32'h00240);
    run(16'hFF80, zero_v, zero_v, 1'b1, 2);
    chk("neg_bias_lit", {15'h0, sat, y}, 32'h0FF80);

    // Abort after two beats; the next run must start from a clean accumulator.
    run(16'h0000, fx, fw, 1'b0, 0);
    bias = 16'h0080;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(bx[0], bw[0]);
    feed(bx[1], bw[1]);
    rst = 1'b1;
    #1;
    chk("reset_midrun", {11'h0, y, sat, out_valid, in_ready, busy}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    run(16'h0080, bx, bw, 1'b0, 0);
    chk("after_reset_lit", {15'h0, sat, y}, 32'h00240);

    // Start held high across three evaluations with downstream always ready.
    hs0 = hs;
    out_ready = 1'b1;
    exp_q.push_back(model(16'h0080, bx, bw));
    exp_q.push_back(model(16'h0000, fx, fw));
    exp_q.push_back(model(16'h0000, px, pw));
    start = 1'b1;
    bias = 16'h0080;
    for (int i = 0; i < N; i++) feed(bx[i], bw[i]);
    bias = 16'h0000;
    for (int i = 0; i < N; i++) feed(fx[i], fw[i]);
    for (int i = 0; i < N; i++) begin
      feed(px[i], pw[i]);
      if (i == N - 1) start = 1'b0;
    end
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    chk("b2b_drained", exp_q.size(), 32'd0);
    chk("b2b_handshakes", hs - hs0, 32'd3);
    out_ready = 1'b0;
    tick();
    chk("b2b_idle", {31'h0, busy}, 32'd0);
    chk("b2b_last_lit", {15'h0, sat, y}, 32'h17FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
